mult: RTL and testbench

- Fully pipelined 32x32 RISC-V M-extension multiplier functional unit covering MUL, MULH, MULHU and MULHSU.
- Accepts one issued instruction per cycle from the issue stage (ISSUE_PACKET).
- Returns the result in an FU_PACKET after a fixed latency, with a data_ready strobe for the complete/writeback stage.
- The pipeline freezes while stall is asserted.

---
 rtl/mult.sv | 185 ++++++++++++++++++
 tb/tb_mult.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult.sv
// Pipelined RISC-V M-extension multiplier (MUL/MULH/MULHU/MULHSU).
// Each stage retires 64/NUM_STAGES multiplier bits by shift-and-add; the last stage drives fu_pack.
package mult_pkg;

    typedef enum logic [2:0] {
        MULT_MUL    = 3'b000,
        MULT_MULH   = 3'b001,
        MULT_MULHSU = 3'b010,
        MULT_MULHU  = 3'b011
    } MULT_FUNC;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } R_TYPE;

    typedef union packed {
        logic [31:0] inst;
        R_TYPE       r;
    } INST;

    typedef struct packed {
        INST         inst;
        logic [31:0] pc;
        logic [4:0]  dest_reg_idx;
        logic        valid;
    } DECODED_VALS;

    typedef struct packed {
        DECODED_VALS decoded_vals;
        logic [5:0]  rob_tag;
    } DECODED_PACK;

    typedef struct packed {
        DECODED_PACK decoded_vals;
        logic [31:0] rs1_value;
        logic [31:0] rs2_value;
    } ISSUE_PACKET;

    typedef struct packed {
        logic [31:0] alu_result;
        INST         inst;
        logic [31:0] pc;
        logic [4:0]  dest_reg_idx;
        logic [5:0]  rob_tag;
    } FU_PACKET;

endpackage

module mult
    import mult_pkg::*;
#(
    parameter int NUM_STAGES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  ISSUE_PACKET is_pack,
    input  logic        stall,
    input  logic        rd_in,
    output FU_PACKET    fu_pack,
    output logic        data_ready
);

    localparam int CHUNK = 64 / NUM_STAGES;

    typedef struct packed {
        INST         inst;
        logic [31:0] pc;
        logic [4:0]  dest_reg_idx;
        logic [5:0]  rob_tag;
    } meta_t;

    typedef struct packed {
        logic        valid;
        MULT_FUNC    func;
        logic [63:0] mcand;
        logic [63:0] mplier;
        logic [63:0] sum;
        meta_t       meta;
    } stage_t;

    stage_t stage_q [NUM_STAGES];
    stage_t stage_d [NUM_STAGES];

    // One pipeline step: add the partial products of the low CHUNK multiplier bits, then realign.
    function automatic stage_t step(input stage_t s);
        stage_t r;
        r = s;
        for (int i = 0; i < CHUNK; i++) begin
            if (s.mplier[i]) begin
                r.sum = r.sum + (s.mcand << i);
            end
        end
        r.mcand  = s.mcand << CHUNK;
        r.mplier = s.mplier >> CHUNK;
        return r;
    endfunction

    logic        in_valid;
    MULT_FUNC    in_func;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [63:0] op_a;
    logic [63:0] op_b;
    stage_t      cap;

    always_comb begin
        in_valid = rd_in & is_pack.decoded_vals.decoded_vals.valid;
        in_func  = MULT_FUNC'(is_pack.decoded_vals.decoded_vals.inst.r.funct3);
        rs1      = is_pack.rs1_value;
        rs2      = is_pack.rs2_value;
        op_a     = '0;
        op_b     = '0;
        case (in_func)
            MULT_MUL, MULT_MULH: begin
                op_a = {{32{rs1[31]}}, rs1};
                op_b = {{32{rs2[31]}}, rs2};
            end
            MULT_MULHU: begin
                op_a = {32'b0, rs1};
                op_b = {32'b0, rs2};
            end
            MULT_MULHSU: begin
                op_a = {{32{rs1[31]}}, rs1};
                op_b = {32'b0, rs2};
            end
            default: begin
                op_a = '0;
                op_b = '0;
            end
        endcase

        // Bubbles enter as all-zero so idle slots stay deterministic.
        cap = '0;
        if (in_valid) begin
            cap.valid             = 1'b1;
            cap.func              = in_func;
            cap.mcand             = op_a;
            cap.mplier            = op_b;
            cap.meta.inst         = is_pack.decoded_vals.decoded_vals.inst;
            cap.meta.pc           = is_pack.decoded_vals.decoded_vals.pc;
            cap.meta.dest_reg_idx = is_pack.decoded_vals.decoded_vals.dest_reg_idx;
            cap.meta.rob_tag      = is_pack.decoded_vals.rob_tag;
        end

        stage_d[0] = step(cap);
        for (int k = 1; k < NUM_STAGES; k++) begin
            stage_d[k] = step(stage_q[k-1]);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else if (!stall) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    stage_t last_stage;
    assign last_stage = stage_q[NUM_STAGES-1];

    always_comb begin
        fu_pack              = '0;
        fu_pack.inst         = last_stage.meta.inst;
        fu_pack.pc           = last_stage.meta.pc;
        fu_pack.dest_reg_idx = last_stage.meta.dest_reg_idx;
        fu_pack.rob_tag      = last_stage.meta.rob_tag;
        case (last_stage.func)
            MULT_MUL:                           fu_pack.alu_result = last_stage.sum[31:0];
            MULT_MULH, MULT_MULHU, MULT_MULHSU: fu_pack.alu_result = last_stage.sum[63:32];
            default:                            fu_pack.alu_result = '0;
        endcase
        data_ready = last_stage.valid;
    end

endmodule

// File: tb/tb_mult.sv
// Self-checking bench for mult: randomised and directed ops, scoreboard queue, reference model in plain arithmetic.
module tb_mult;
    import mult_pkg::*;

    localparam int NS = 4;

    logic        clock = 1'b0;
    logic        reset;
    ISSUE_PACKET is_pack;
    logic        stall;
    logic        rd_in;
    FU_PACKET    fu_pack;
    logic        data_ready;

    mult #(.NUM_STAGES(NS)) dut (
        .clock     (clock),
        .reset     (reset),
        .is_pack   (is_pack),
        .stall     (stall),
        .rd_in     (rd_in),
        .fu_pack   (fu_pack),
        .data_ready(data_ready)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] due;
        logic [31:0] result;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [5:0]  tag;
    } exp_t;

    localparam int EW = $bits(exp_t);

    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            act_cnt = 0;
    logic          last_active = 1'b0;
    logic          model_dr = 1'b0;
    exp_t          cur_exp = '0;

    // Reference: extend per the instruction's signedness, take the 64-bit product, pick the half.
    function automatic logic [31:0] ref_mult(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (f)
            3'b000, 3'b001: p = sa * sb;
            3'b010:         p = sa * ub;
            3'b011:         p = ua * ub;
            default:        return 32'h0;
        endcase
        return (f == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard push: an op is accepted on a non-stalled edge outside reset.
    always @(posedge clock) begin : sb_push
        exp_t e;
        last_active = 1'b0;
        if (reset) begin
            exp_q.delete();
        end else if (!stall) begin
            act_cnt++;
            last_active = 1'b1;
            if (rd_in && is_pack.decoded_vals.decoded_vals.valid) begin
                e.due    = 32'(act_cnt + NS - 1);
                e.result = ref_mult(is_pack.rs1_value, is_pack.rs2_value,
                                    is_pack.decoded_vals.decoded_vals.inst.r.funct3);
                e.inst   = is_pack.decoded_vals.decoded_vals.inst.inst;
                e.pc     = is_pack.decoded_vals.decoded_vals.pc;
                e.dest   = is_pack.decoded_vals.decoded_vals.dest_reg_idx;
                e.tag    = is_pack.decoded_vals.rob_tag;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: the model decides what the output should show after every edge, then compares.
    always @(negedge clock) begin : monitor
        exp_t e;
        if (reset) begin
            model_dr = 1'b0;
            check("rst_data_ready", 64'(data_ready), 64'd0);
            check("rst_alu_result", 64'(fu_pack.alu_result), 64'd0);
            check("rst_meta", 64'({fu_pack.pc, fu_pack.dest_reg_idx, fu_pack.rob_tag}), 64'd0);
        end else begin
            if (last_active) begin
                model_dr = 1'b0;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    if (e.due == 32'(act_cnt)) begin
                        cur_exp  = exp_q.pop_front();
                        model_dr = 1'b1;
                    end
                end
            end
            check("data_ready", 64'(data_ready), 64'(model_dr));
            if (model_dr) begin
                check("alu_result", 64'(fu_pack.alu_result), 64'(cur_exp.result));
                check("inst", 64'(fu_pack.inst.inst), 64'(cur_exp.inst));
                check("pc", 64'(fu_pack.pc), 64'(cur_exp.pc));
                check("dest_reg_idx", 64'(fu_pack.dest_reg_idx), 64'(cur_exp.dest));
                check("rob_tag", 64'(fu_pack.rob_tag), 64'(cur_exp.tag));
            end
        end
    end

    // Driver: present one op for one cycle; caller is at a negedge.
    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f, input logic v);
        is_pack = '0;
        is_pack.decoded_vals.decoded_vals.inst.inst     = $urandom;
        is_pack.decoded_vals.decoded_vals.inst.r.funct3 = f;
        is_pack.decoded_vals.decoded_vals.pc            = $urandom;
        is_pack.decoded_vals.decoded_vals.dest_reg_idx  = 5'($urandom_range(0, 31));
        is_pack.decoded_vals.decoded_vals.valid         = v;
        is_pack.decoded_vals.rob_tag                    = 6'($urandom_range(0, 63));
        is_pack.rs1_value                               = a;
        is_pack.rs2_value                               = b;
        rd_in = 1'b1;
        @(negedge clock);
    endtask

    task automatic idle(input int n);
        rd_in = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    logic [31:0] small_a [7] = '{32'd0, 32'd1, 32'd0, 32'd3, 32'd2, 32'd15, 32'd30};
    logic [31:0] small_b [7] = '{32'd0, 32'd0, 32'd1, 32'd4, 32'd15, 32'd2, 32'd30};

    initial begin
        reset   = 1'b1;
        stall   = 1'b0;
        rd_in   = 1'b0;
        is_pack = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        idle(2);

        // Small MUL values, one at a time
        for (int i = 0; i < 7; i++) begin
            drive(small_a[i], small_b[i], 3'b000, 1'b1);
            idle(NS + 1);
        end

        // Mixed signs and the 0xC0000000 corner in both orders, every func
        for (int f = 0; f < 4; f++) begin
            drive(32'hff123456, 32'hfffff888, 3'(f), 1'b1);
            idle(NS + 1);
            drive(32'hC0000000, 32'd4, 3'(f), 1'b1);
            idle(NS + 1);
            drive(32'd4, 32'hC0000000, 3'(f), 1'b1);
            idle(NS + 1);
        end

        // Unsupported funct3 values and an op whose valid bit is clear
        for (int f = 4; f < 8; f++) begin
            drive($urandom, $urandom, 3'(f), 1'b1);
        end
        drive(32'd7, 32'd9, 3'b000, 1'b0);
        idle(NS + 2);

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 3'($urandom_range(0, 3)), 1'b1);
        end
        idle(NS + 2);

        // Stall for 3 cycles with the first result on the output; an op offered during the stall is ignored
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 3'($urandom_range(0, 3)), 1'b1);
        end
        stall = 1'b1;
        drive(32'd5, 32'd6, 3'b000, 1'b1);
        drive(32'd7, 32'd8, 3'b001, 1'b1);
        drive(32'd9, 32'd10, 3'b011, 1'b1);
        stall = 1'b0;
        idle(NS + 2);

        // Reset while results are in flight and one is being presented
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 3'($urandom_range(0, 3)), 1'b1);
        end
        #2 reset = 1'b1;
        #1;
        check("async_rst_data_ready", 64'(data_ready), 64'd0);
        check("async_rst_alu_result", 64'(fu_pack.alu_result), 64'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        idle(NS + 4);

        // Random operands, 10 per func, with random gaps and occasional stalls
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 10; i++) begin
                stall = ($urandom_range(0, 5) == 0);
                drive($urandom, $urandom, 3'(f), 1'b1);
                stall = 1'b0;
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
            end
        end
        stall = 1'b0;
        idle(NS + 4);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
